// File: rtl/leaf_queue_pkg.sv
// Shared widths and request payload for the leaf request queue.
package leaf_queue_pkg;

   localparam int unsigned ADDRESS_WIDTH  = 8;
   localparam int unsigned QUERY_ID_WIDTH = 12;
   localparam int unsigned DEPTH          = 32;
   // 6 tree stages x 2 lanes in flight, plus 2 entries of slack
   localparam int unsigned AF_MARGIN      = 14;
   localparam int unsigned AF_THRESHOLD   = DEPTH - AF_MARGIN;
   localparam int unsigned PTR_W          = $clog2(DEPTH);
   localparam int unsigned CNT_W          = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic                      lane;
      logic [QUERY_ID_WIDTH-1:0] query_id;
      logic [ADDRESS_WIDTH-1:0]  leaf_index;
   } leaf_req_t;

endpackage

// File: rtl/leaf_queue_storage.sv
// Register array with two write ports and one asynchronous read port.
module leaf_queue_storage
   import leaf_queue_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_a_en,
   input  logic [PTR_W-1:0] wr_a_addr,
   input  leaf_req_t        wr_a_data,
   input  logic             wr_b_en,
   input  logic [PTR_W-1:0] wr_b_addr,
   input  leaf_req_t        wr_b_data,
   input  logic [PTR_W-1:0] rd_addr,
   output leaf_req_t        rd_data
);

   leaf_req_t mem [DEPTH];

   // Entry storage; the two write addresses are never equal in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_a_en) mem[wr_a_addr] <= wr_a_data;
         if (wr_b_en) mem[wr_b_addr] <= wr_b_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/leaf_request_queue.sv
// Two-lane leaf result queue serialised into one valid/ready request stream.
module leaf_request_queue
   import leaf_queue_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic [ADDRESS_WIDTH-1:0]  leaf_index,
   input  logic                      receiver_en,
   input  logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
   input  logic                      receiver_two_en,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDRESS_WIDTH-1:0]  out_leaf_index,
   output logic                      out_lane,
   output logic [QUERY_ID_WIDTH-1:0] out_query_id,
   output logic [CNT_W-1:0]          count,
   output logic                      almost_full,
   output logic                      overflow
);

   logic [PTR_W-1:0]          wp, rp, wp_next, rp_next;
   logic [CNT_W-1:0]          count_next, free;
   logic [QUERY_ID_WIDTH-1:0] qid0, qid1, qid0_next, qid1_next;
   logic                      overflow_next;
   logic                      pop;
   logic                      wr_a_en, wr_b_en;
   logic [1:0]                n_stored;
   leaf_req_t                 req0, req1, wr_a_data, head;

   assign req0 = '{lane: 1'b0, query_id: qid0, leaf_index: leaf_index};
   assign req1 = '{lane: 1'b1, query_id: qid1, leaf_index: leaf_index_two};

   // Arbitration of both lanes against free slots, pointer/counter/flag next state
   always_comb begin
      pop           = out_valid && out_ready;
      free          = CNT_W'(DEPTH) - count + CNT_W'(pop);
      wr_a_en       = 1'b0;
      wr_b_en       = 1'b0;
      wr_a_data     = req0;
      n_stored      = 2'd0;
      wp_next       = wp;
      rp_next       = rp;
      count_next    = count;
      qid0_next     = qid0;
      qid1_next     = qid1;
      overflow_next = overflow;

      if (clear) begin
         wp_next       = '0;
         rp_next       = '0;
         count_next    = '0;
         qid0_next     = '0;
         qid1_next     = '0;
         overflow_next = 1'b0;
      end else begin
         if (receiver_en && receiver_two_en) begin
            if (free >= CNT_W'(2)) begin
               wr_a_en  = 1'b1;
               wr_b_en  = 1'b1;
               n_stored = 2'd2;
            end else if (free == CNT_W'(1)) begin
               wr_a_en       = 1'b1;
               n_stored      = 2'd1;
               overflow_next = 1'b1;
            end else begin
               overflow_next = 1'b1;
            end
         end else if (receiver_en || receiver_two_en) begin
            // A lone lane-1 result takes the first write port
            wr_a_data = receiver_en ? req0 : req1;
            if (free != '0) begin
               wr_a_en  = 1'b1;
               n_stored = 2'd1;
            end else begin
               overflow_next = 1'b1;
            end
         end

         wp_next    = wp + PTR_W'(n_stored);
         rp_next    = rp + PTR_W'(pop);
         count_next = count + CNT_W'(n_stored) - CNT_W'(pop);
         qid0_next  = qid0 + QUERY_ID_WIDTH'(receiver_en);
         qid1_next  = qid1 + QUERY_ID_WIDTH'(receiver_two_en);
      end
   end

   // Pointer, occupancy, tag counter and sticky overflow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         qid0     <= '0;
         qid1     <= '0;
         overflow <= 1'b0;
      end else begin
         wp       <= wp_next;
         rp       <= rp_next;
         count    <= count_next;
         qid0     <= qid0_next;
         qid1     <= qid1_next;
         overflow <= overflow_next;
      end
   end

   leaf_queue_storage u_storage (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_a_en   (wr_a_en),
      .wr_a_addr (wp),
      .wr_a_data (wr_a_data),
      .wr_b_en   (wr_b_en),
      .wr_b_addr (wp + PTR_W'(1)),
      .wr_b_data (req1),
      .rd_addr   (rp),
      .rd_data   (head)
   );

   assign out_valid      = (count != '0);
   assign almost_full    = (count >= CNT_W'(AF_THRESHOLD));
   assign out_leaf_index = head.leaf_index;
   assign out_lane       = head.lane;
   assign out_query_id   = head.query_id;

endmodule
